// File: rtl/spi_accel_responder_pkg.sv
// rtl/spi_accel_responder_pkg.sv - register map, FSM encoding and helpers for the accelerometer SPI responder
package spi_accel_responder_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam int INT_DATA_READY = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_READ,
        ST_WRITE
    } spi_state_e;

    function automatic logic is_data_addr(input logic [5:0] addr);
        return (addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1);
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - multi-stage synchronizer with rise/fall pulses on the low EDGE_WIDTH bits
module spi_in_sync #(
    parameter int                 WIDTH      = 3,
    parameter int                 EDGE_WIDTH = 2,
    parameter int                 STAGES     = 2,
    parameter logic [WIDTH-1:0]   RST_VAL    = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [EDGE_WIDTH-1:0] rise,
    output logic [EDGE_WIDTH-1:0] fall
);

    logic [WIDTH-1:0]      stage_q [STAGES];
    logic [WIDTH-1:0]      stage_d [STAGES];
    logic [EDGE_WIDTH-1:0] prev_q;
    logic [EDGE_WIDTH-1:0] prev_d;

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        prev_d = dout[EDGE_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
            prev_q <= RST_VAL[EDGE_WIDTH-1:0];
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
            prev_q <= prev_d;
        end
    end

    assign dout = stage_q[STAGES-1];
    assign rise = dout[EDGE_WIDTH-1:0] & ~prev_q;
    assign fall = ~dout[EDGE_WIDTH-1:0] & prev_q;

endmodule

// File: rtl/spi_accel_responder.sv
// rtl/spi_accel_responder.sv - mode-3 SPI slave emulating the accelerometer register interface
module spi_accel_responder #(
    parameter logic [7:0] DEVID_VAL   = 8'hE5,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_csn,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        spi_sdo_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic        int1,
    output logic [7:0]  power_ctl,
    output logic [7:0]  data_format,
    output logic        busy
);

    import spi_accel_responder_pkg::*;

    logic [2:0] sync_lvl;
    logic [1:0] sync_rise;
    logic [1:0] sync_fall;
    logic       sync_unused;

    spi_in_sync #(
        .WIDTH      (3),
        .EDGE_WIDTH (2),
        .STAGES     (SYNC_STAGES),
        .RST_VAL    (3'b011)
    ) u_in_sync (
        .clk  (clk),
        .rst  (rst),
        .din  ({spi_sdi, spi_csn, spi_sclk}),
        .dout (sync_lvl),
        .rise (sync_rise),
        .fall (sync_fall)
    );

    logic csn_s, sdi_s, sclk_rise, sclk_fall, csn_rise, csn_fall;
    assign sync_unused = sync_lvl[0];
    assign csn_s       = sync_lvl[1];
    assign sdi_s       = sync_lvl[2];
    assign sclk_rise   = sync_rise[0];
    assign sclk_fall   = sync_fall[0];
    assign csn_rise    = sync_rise[1];
    assign csn_fall    = sync_fall[1];

    spi_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic        sdo_q, sdo_d;
    logic [5:0]  addr_q, addr_d;
    logic        mb_q, mb_d;
    logic        rd_hit_q, rd_hit_d;
    logic [7:0]  bw_rate_q, bw_rate_d;
    logic [7:0]  power_ctl_q, power_ctl_d;
    logic [7:0]  int_enable_q, int_enable_d;
    logic [7:0]  data_format_q, data_format_d;
    logic [47:0] data_q, data_d;
    logic [47:0] shadow_q, shadow_d;
    logic        pending_q, pending_d;
    logic        data_ready_q, data_ready_d;
    logic        int1_q, int1_d;

    logic [7:0] rx_byte;
    logic [5:0] addr_adv;
    logic [5:0] rd_addr;
    logic [7:0] rd_byte;
    logic       wr_en;
    logic       apply;

    assign rx_byte  = {shift_q, sdi_s};
    assign addr_adv = mb_q ? addr_q + 6'd1 : addr_q;
    // The only two register reads: the command's own address, or the next byte of a burst.
    assign rd_addr  = (state_q == ST_CMD) ? rx_byte[5:0] : addr_adv;
    assign apply    = pending_q & csn_s;

    always_comb begin
        rd_byte = 8'h00;
        case (rd_addr)
            ADDR_DEVID:       rd_byte = DEVID_VAL;
            ADDR_BW_RATE:     rd_byte = bw_rate_q;
            ADDR_POWER_CTL:   rd_byte = power_ctl_q;
            ADDR_INT_ENABLE:  rd_byte = int_enable_q;
            ADDR_DATA_FORMAT: rd_byte = data_format_q;
            ADDR_DATAX0:      rd_byte = data_q[7:0];
            ADDR_DATAX1:      rd_byte = data_q[15:8];
            ADDR_DATAY0:      rd_byte = data_q[23:16];
            ADDR_DATAY1:      rd_byte = data_q[31:24];
            ADDR_DATAZ0:      rd_byte = data_q[39:32];
            ADDR_DATAZ1:      rd_byte = data_q[47:40];
            default:          rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tx_d          = tx_q;
        sdo_d         = sdo_q;
        addr_d        = addr_q;
        mb_d          = mb_q;
        rd_hit_d      = rd_hit_q;
        bw_rate_d     = bw_rate_q;
        power_ctl_d   = power_ctl_q;
        int_enable_d  = int_enable_q;
        data_format_d = data_format_q;
        data_d        = data_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        data_ready_d  = data_ready_q;
        wr_en         = 1'b0;

        if (csn_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            rd_hit_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csn_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = rx_byte[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            mb_d   = rx_byte[6];
                            addr_d = rx_byte[5:0];
                            if (rx_byte[7]) begin
                                state_d = ST_READ;
                                tx_d    = rd_byte;
                            end else begin
                                state_d = ST_WRITE;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (sclk_fall) begin
                        sdo_d = tx_q[7];
                        tx_d  = {tx_q[6:0], 1'b0};
                    end
                    // Byte ends when the master samples its last bit; reload for the next fall.
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = addr_adv;
                            tx_d   = rd_byte;
                            if (is_data_addr(addr_q)) begin
                                rd_hit_d = 1'b1;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = rx_byte[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            wr_en  = 1'b1;
                            addr_d = addr_adv;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (wr_en) begin
            case (addr_q)
                ADDR_BW_RATE:     bw_rate_d     = rx_byte;
                ADDR_POWER_CTL:   power_ctl_d   = rx_byte;
                ADDR_INT_ENABLE:  int_enable_d  = rx_byte;
                ADDR_DATA_FORMAT: data_format_d = rx_byte;
                default:          ;
            endcase
        end

        if (apply) begin
            data_d    = shadow_q;
            pending_d = 1'b0;
        end
        if (sample_valid) begin
            shadow_d  = {sample_z, sample_y, sample_x};
            pending_d = 1'b1;
        end

        if (csn_rise && rd_hit_q) begin
            data_ready_d = 1'b0;
        end
        if (apply) begin
            data_ready_d = 1'b1;
        end

        int1_d = data_ready_q & int_enable_q[INT_DATA_READY];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 7'd0;
            tx_q          <= 8'h00;
            sdo_q         <= 1'b0;
            addr_q        <= 6'd0;
            mb_q          <= 1'b0;
            rd_hit_q      <= 1'b0;
            bw_rate_q     <= BW_RATE_RST;
            power_ctl_q   <= 8'h00;
            int_enable_q  <= 8'h00;
            data_format_q <= 8'h00;
            data_q        <= 48'd0;
            shadow_q      <= 48'd0;
            pending_q     <= 1'b0;
            data_ready_q  <= 1'b0;
            int1_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
            sdo_q         <= sdo_d;
            addr_q        <= addr_d;
            mb_q          <= mb_d;
            rd_hit_q      <= rd_hit_d;
            bw_rate_q     <= bw_rate_d;
            power_ctl_q   <= power_ctl_d;
            int_enable_q  <= int_enable_d;
            data_format_q <= data_format_d;
            data_q        <= data_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            data_ready_q  <= data_ready_d;
            int1_q        <= int1_d;
        end
    end

    assign spi_sdo     = sdo_q;
    assign spi_sdo_oe  = ~csn_s;
    assign busy        = ~csn_s;
    assign int1        = int1_q;
    assign power_ctl   = power_ctl_q;
    assign data_format = data_format_q;

endmodule

// File: tb/tb_spi_accel_responder.sv
// tb/tb_spi_accel_responder.sv - randomized self-checking bench against a register-map reference model
module tb_spi_accel_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        spi_sclk = 1'b1;
    logic        spi_csn = 1'b1;
    logic        spi_sdi = 1'b0;
    logic        spi_sdo;
    logic        spi_sdo_oe;
    logic [15:0] sample_x = '0;
    logic [15:0] sample_y = '0;
    logic [15:0] sample_z = '0;
    logic        sample_valid = 1'b0;
    logic        int1;
    logic [7:0]  power_ctl;
    logic [7:0]  data_format;
    logic        busy;

    always #5 clk = ~clk;

    spi_accel_responder dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sclk     (spi_sclk),
        .spi_csn      (spi_csn),
        .spi_sdi      (spi_sdi),
        .spi_sdo      (spi_sdo),
        .spi_sdo_oe   (spi_sdo_oe),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .sample_z     (sample_z),
        .sample_valid (sample_valid),
        .int1         (int1),
        .power_ctl    (power_ctl),
        .data_format  (data_format),
        .busy         (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: a plain byte array for the register map plus sample bookkeeping.
    logic [7:0]  m_reg [64];
    logic [47:0] m_sh;
    bit          m_pend;
    bit          m_dr;
    bit          m_in_frame;

    logic [7:0]  wbuf [8];
    logic [7:0]  rbuf [8];
    bit          mp_en;
    bit          mp_at_end;
    int          mp_byte;
    logic [15:0] mp_x, mp_y, mp_z;

    function automatic bit m_writable(input logic [5:0] a);
        return (a == 6'h2C) || (a == 6'h2D) || (a == 6'h2E) || (a == 6'h31);
    endfunction

    task automatic m_apply(input logic [47:0] s);
        for (int i = 0; i < 6; i++) m_reg[6'h32 + i] = s[8*i +: 8];
        m_dr = 1'b1;
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge clk);
        sample_x = x; sample_y = y; sample_z = z; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        if (m_in_frame) begin
            m_sh = {z, y, x};
            m_pend = 1'b1;
        end else begin
            m_apply({z, y, x});
        end
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input int nbytes, input int part_bits);
        logic [5:0] a;
        bit         hit;
        logic [7:0] txb;
        int         nb;
        a = cmd[5:0];
        hit = 1'b0;
        nb = 8 * (nbytes + 1) + part_bits;
        @(negedge clk);
        spi_csn = 1'b0;
        m_in_frame = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("busy_frame", busy, 1'b1);
        check_eq("oe_frame", spi_sdo_oe, 1'b1);
        for (int b = 0; b < nb; b++) begin
            txb = (b < 8) ? cmd : wbuf[b/8 - 1];
            spi_sclk = 1'b0;
            spi_sdi = txb[7 - b%8];
            repeat (8) @(negedge clk);
            if (b >= 8) rbuf[b/8 - 1][7 - b%8] = spi_sdo;
            spi_sclk = 1'b1;
            repeat (8) @(negedge clk);
            if (b % 8 == 7 && b >= 8) begin
                if (cmd[7]) begin
                    check_eq("rd_byte", rbuf[b/8 - 1], m_reg[a]);
                    if (a >= 6'h32 && a <= 6'h37) hit = 1'b1;
                end else if (m_writable(a)) begin
                    m_reg[a] = wbuf[b/8 - 1];
                end
                if (cmd[6]) a = a + 6'd1;
                if (mp_en && !mp_at_end && (b/8 == mp_byte)) pulse_sample(mp_x, mp_y, mp_z);
            end
        end
        spi_csn = 1'b1;
        if (mp_en && mp_at_end) pulse_sample(mp_x, mp_y, mp_z);
        m_in_frame = 1'b0;
        mp_en = 1'b0;
        if (m_pend) begin
            m_apply(m_sh);
            m_pend = 1'b0;
        end else if (hit) begin
            m_dr = 1'b0;
        end
        repeat (10) @(negedge clk);
        check_eq("busy_idle", busy, 1'b0);
        check_eq("oe_idle", spi_sdo_oe, 1'b0);
    endtask

    task automatic check_model_outputs(input string tag);
        check_eq({tag, "_pwr"}, power_ctl, m_reg[6'h2D]);
        check_eq({tag, "_fmt"}, data_format, m_reg[6'h31]);
        check_eq({tag, "_int1"}, int1, m_dr & m_reg[6'h2E][7]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_b [6];
        logic [5:0] addr_list [8];
        logic [5:0] ra;
        int         nbytes;
        int         part;

        for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
        m_reg[6'h00] = 8'hE5;
        m_reg[6'h2C] = 8'h0A;
        m_sh = '0; m_pend = 0; m_dr = 0; m_in_frame = 0;
        mp_en = 0; mp_at_end = 0; mp_byte = 0;
        addr_list = '{6'h00, 6'h2C, 6'h2D, 6'h2E, 6'h31, 6'h32, 6'h35, 6'h3F};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_sdo", spi_sdo, 1'b0);
        check_eq("rst_oe", spi_sdo_oe, 1'b0);
        check_eq("rst_int1", int1, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_pwr", power_ctl, 8'h00);
        check_eq("rst_fmt", data_format, 8'h00);

        spi_frame(8'h80, 1, 0);
        check_eq("devid", rbuf[0], 8'hE5);
        check_eq("devid_int1", int1, 1'b0);
        spi_frame(8'hAC, 1, 0);
        check_eq("bw_rate_rst", rbuf[0], 8'h0A);

        pulse_sample(16'h0123, 16'hFF9C, 16'h00FA);
        repeat (4) @(negedge clk);
        spi_frame(8'hF2, 6, 0);
        exp_b = '{8'h23, 8'h01, 8'h9C, 8'hFF, 8'hFA, 8'h00};
        for (int i = 0; i < 6; i++) check_eq("burst", rbuf[i], exp_b[i]);

        wbuf[0] = 8'h08;
        spi_frame(8'h2D, 1, 0);
        check_eq("pwr_write", power_ctl, 8'h08);
        spi_frame(8'hAD, 1, 0);
        check_eq("pwr_readback", rbuf[0], 8'h08);
        wbuf[0] = 8'h55;
        spi_frame(8'h00, 1, 0);
        spi_frame(8'h80, 1, 0);
        check_eq("devid_ro", rbuf[0], 8'hE5);

        pulse_sample(16'h1111, 16'h0000, 16'h0000);
        repeat (4) @(negedge clk);
        mp_en = 1; mp_at_end = 0; mp_byte = 1;
        mp_x = 16'h2222; mp_y = 16'h0000; mp_z = 16'h0000;
        spi_frame(8'hF2, 2, 0);
        check_eq("coh_b0", rbuf[0], 8'h11);
        check_eq("coh_b1", rbuf[1], 8'h11);
        spi_frame(8'hF2, 2, 0);
        check_eq("coh_new_b0", rbuf[0], 8'h22);
        check_eq("coh_new_b1", rbuf[1], 8'h22);

        wbuf[0] = 8'h80;
        spi_frame(8'h2E, 1, 0);
        check_eq("int1_before", int1, 1'b0);
        pulse_sample(16'h0A0A, 16'h0B0B, 16'h0C0C);
        repeat (2) @(negedge clk);
        check_eq("int1_set", int1, 1'b1);
        spi_frame(8'hF2, 6, 0);
        check_eq("int1_clear", int1, 1'b0);
        pulse_sample(16'h1234, 16'h5678, 16'h9ABC);
        repeat (4) @(negedge clk);
        check_eq("int1_set2", int1, 1'b1);
        mp_en = 1; mp_at_end = 1;
        mp_x = 16'h4321; mp_y = 16'h8765; mp_z = 16'hCBA9;
        spi_frame(8'hF2, 6, 0);
        check_eq("int1_set_wins", int1, 1'b1);
        check_model_outputs("int_dir");

        wbuf[0] = 8'hFF;
        spi_frame(8'h2D, 0, 4);
        check_eq("abort_pwr", power_ctl, 8'h08);
        spi_frame(8'hFF, 2, 0);
        check_eq("wrap_3f", rbuf[0], 8'h00);
        check_eq("wrap_00", rbuf[1], 8'hE5);

        for (int it = 0; it < 30; it++) begin
            ra = ($urandom_range(0, 1) == 0) ? addr_list[$urandom_range(0, 7)] : 6'($urandom_range(0, 63));
            nbytes = $urandom_range(1, 4);
            part = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            case ($urandom_range(0, 3))
                0: begin
                    pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
                    repeat (4) @(negedge clk);
                end
                1: begin
                    for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
                    spi_frame({1'b0, 1'($urandom_range(0, 1)), ra}, nbytes, part);
                end
                default: begin
                    if ($urandom_range(0, 2) == 0) begin
                        mp_en = 1;
                        mp_at_end = 1'($urandom_range(0, 1));
                        mp_byte = $urandom_range(1, nbytes);
                        mp_x = 16'($urandom); mp_y = 16'($urandom); mp_z = 16'($urandom);
                    end
                    spi_frame({1'b1, 1'($urandom_range(0, 1)), ra}, nbytes, part);
                end
            endcase
            check_model_outputs("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
